// File: rtl/uart_tx_scheduler.sv
// Shares one 8N1 serial transmitter between two requesters (A, B) using round-robin arbitration.
// The 16x oversampling tick from the baud-rate generator paces all frame timing.
`timescale 1ns/1ps

module uart_tx_scheduler #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int STOP_TICKS = 16
) (
    input  logic                 clock,
    input  logic                 reset_i,
    input  logic                 tick,
    input  logic                 req_a_i,
    input  logic [DATA_BITS-1:0] data_a_i,
    input  logic                 req_b_i,
    input  logic [DATA_BITS-1:0] data_b_i,
    output logic                 grant_a_o,
    output logic                 grant_b_o,
    output logic                 owner_o,
    output logic                 tx_busy_o,
    output logic                 tx_done_o,
    output logic                 tx_o
);

    // The tick counter must hold the longer of a bit cell and the stop bit.
    localparam int CW = $clog2(OVERSAMPLE > STOP_TICKS ? OVERSAMPLE : STOP_TICKS);
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [CW-1:0] BIT_LAST  = CW'(OVERSAMPLE - 1);
    localparam logic [CW-1:0] STOP_LAST = CW'(STOP_TICKS - 1);
    localparam logic [BW-1:0] IDX_LAST  = BW'(DATA_BITS - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t               state;
    logic [CW-1:0]        tick_cnt;
    logic [BW-1:0]        bit_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 last_grant;  // 0 = A, 1 = B
    logic                 pick_b;

    // On a tie, the requester that did not win last time gets the line.
    always_comb begin
        pick_b = req_b_i && (!req_a_i || !last_grant);
    end

    // NOTE: every register here, including the shift register, is cleared by the async reset
    // and updated with non-blocking assignments, so all of it changes together at one edge.
    always_ff @(posedge clock or posedge reset_i) begin
        if (reset_i) begin
            state      <= IDLE;
            tick_cnt   <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            last_grant <= 1'b1;
            grant_a_o  <= 1'b0;
            grant_b_o  <= 1'b0;
            owner_o    <= 1'b0;
            tx_busy_o  <= 1'b0;
            tx_done_o  <= 1'b0;
            tx_o       <= 1'b1;
        end else begin
            grant_a_o <= 1'b0;
            grant_b_o <= 1'b0;
            tx_done_o <= 1'b0;

            case (state)
                IDLE: begin
                    if (req_a_i || req_b_i) begin
                        grant_a_o  <= !pick_b;
                        grant_b_o  <= pick_b;
                        shreg      <= pick_b ? data_b_i : data_a_i;
                        owner_o    <= pick_b;
                        last_grant <= pick_b;
                        tx_busy_o  <= 1'b1;
                        tick_cnt   <= '0;
                        tx_o       <= 1'b0;
                        state      <= START;
                    end
                end

                START: begin
                    if (tick) begin
                        if (tick_cnt == BIT_LAST) begin
                            tick_cnt <= '0;
                            bit_idx  <= '0;
                            tx_o     <= shreg[0];
                            state    <= DATA;
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end

                DATA: begin
                    if (tick) begin
                        if (tick_cnt == BIT_LAST) begin
                            tick_cnt <= '0;
                            shreg    <= shreg >> 1;
                            if (bit_idx == IDX_LAST) begin
                                tx_o  <= 1'b1;
                                state <= STOP;
                            end else begin
                                bit_idx <= bit_idx + 1'b1;
                                tx_o    <= shreg[1];
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end

                STOP: begin
                    if (tick) begin
                        if (tick_cnt == STOP_LAST) begin
                            tick_cnt  <= '0;
                            tx_done_o <= 1'b1;
                            tx_busy_o <= 1'b0;
                            state     <= IDLE;
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Self-checking bench for uart_tx_scheduler: a tick-indexed line model checks each frame,
// and a round-robin model predicts which requester wins each grant.
`timescale 1ns/1ps

module tb_uart_tx_scheduler;

    localparam int DB          = 8;
    localparam int OS          = 16;
    localparam int ST          = 16;
    localparam int FRAME_TICKS = (1 + DB) * OS + ST;

    logic          clock = 1'b0;
    logic          reset_i;
    logic          tick;
    logic          req_a_i, req_b_i;
    logic [DB-1:0] data_a_i, data_b_i;
    logic          grant_a_o, grant_b_o, owner_o, tx_busy_o, tx_done_o, tx_o;

    int checks = 0;
    int fails  = 0;
    bit tick_en = 1'b0;
    int div = 0;
    bit model_last = 1'b1;  // 1 = B won last

    uart_tx_scheduler #(.DATA_BITS(DB), .OVERSAMPLE(OS), .STOP_TICKS(ST)) dut (
        .clock(clock), .reset_i(reset_i), .tick(tick),
        .req_a_i(req_a_i), .data_a_i(data_a_i),
        .req_b_i(req_b_i), .data_b_i(data_b_i),
        .grant_a_o(grant_a_o), .grant_b_o(grant_b_o), .owner_o(owner_o),
        .tx_busy_o(tx_busy_o), .tx_done_o(tx_done_o), .tx_o(tx_o)
    );

    initial forever #5 clock = ~clock;

    // One tick strobe every 4 clocks, changed on the falling edge only.
    initial begin
        tick = 1'b0;
        forever begin
            @(negedge clock);
            div  = (div + 1) % 4;
            tick = tick_en && (div == 0);
        end
    end

    // Expected line level once n ticks of the frame have elapsed.
    function automatic logic exp_line(input int n, input logic [DB-1:0] b);
        if (n < OS) return 1'b0;
        if (n < (1 + DB) * OS) return b[(n - OS) / OS];
        return 1'b1;
    endfunction

    task automatic do_reset();
        @(negedge clock);
        reset_i = 1'b1;
        repeat (2) @(negedge clock);
        reset_i = 1'b0;
        model_last = 1'b1;
    endtask

    // Waits up to budget falling edges for a grant and checks the winner against the model.
    task automatic check_grant(input string name, input int budget, output logic win_b);
        logic ra, rb, got_a, got_b;
        ra = req_a_i;
        rb = req_b_i;
        win_b = (ra && rb) ? !model_last : rb;
        got_a = 1'b0;
        got_b = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clock);
            if (grant_a_o || grant_b_o) begin
                got_a = grant_a_o;
                got_b = grant_b_o;
                break;
            end
        end
        checks++;
        if (!(got_a ^ got_b) || got_b !== win_b || owner_o !== win_b || tx_busy_o !== 1'b1) begin
            fails++;
            $display("FAIL %s grant: got a=%b b=%b owner=%b busy=%b, want b=%b owner=%b busy=1 within %0d clk",
                     name, got_a, got_b, owner_o, tx_busy_o, win_b, win_b, budget);
        end
        model_last = win_b;
    endtask

    // Follows one frame from the grant falling edge to the done falling edge.
    task automatic follow_frame(input string name, input logic [DB-1:0] b, input logic own,
                                output int busy_clks);
        int n = 0, steps = 0, line_err = 0, first_bad = -1, ctl_err = 0, grant_err = 0;
        logic first_got = 1'b0;
        busy_clks = tx_busy_o ? 1 : 0;
        if (tx_o !== exp_line(0, b)) begin
            line_err++;
            first_bad = 0;
            first_got = tx_o;
        end
        while (n < FRAME_TICKS && steps < FRAME_TICKS * 8) begin
            @(posedge clock);
            if (tick) n++;
            @(negedge clock);
            steps++;
            if (tx_busy_o) busy_clks++;
            if (n < FRAME_TICKS) begin
                if (tx_o !== exp_line(n, b)) begin
                    if (line_err == 0) begin
                        first_bad = n;
                        first_got = tx_o;
                    end
                    line_err++;
                end
                if (tx_busy_o !== 1'b1 || tx_done_o !== 1'b0 || owner_o !== own) ctl_err++;
                if (grant_a_o || grant_b_o) grant_err++;
            end
        end
        checks++;
        if (n < FRAME_TICKS) begin
            fails++;
            $display("FAIL %s timeout: got %0d ticks, want %0d", name, n, FRAME_TICKS);
        end
        checks++;
        if (line_err != 0) begin
            fails++;
            $display("FAIL %s line: %0d bad cycles, first at tick %0d got %b want %b (byte %h)",
                     name, line_err, first_bad, first_got, exp_line(first_bad, b), b);
        end
        checks++;
        if (ctl_err != 0) begin
            fails++;
            $display("FAIL %s busy/owner: %0d bad cycles, want busy=1 done=0 owner=%b", name, ctl_err, own);
        end
        checks++;
        if (grant_err != 0) begin
            fails++;
            $display("FAIL %s grant_while_busy: got %0d grants, want 0", name, grant_err);
        end
        checks++;
        if (tx_done_o !== 1'b1 || tx_busy_o !== 1'b0 || tx_o !== 1'b1) begin
            fails++;
            $display("FAIL %s end: got done=%b busy=%b tx=%b, want 1 0 1", name, tx_done_o, tx_busy_o, tx_o);
        end
    endtask

    task automatic test_reset();
        int err = 0, bc;
        logic wb;
        logic [DB-1:0] b;
        b = DB'($urandom);
        reset_i = 1'b1; req_a_i = 1'b1; req_b_i = 1'b0; data_a_i = b; data_b_i = '0;
        tick_en = 1'b0;
        repeat (5) begin
            @(negedge clock);
            if (tx_o !== 1'b1 || grant_a_o || grant_b_o || tx_busy_o || tx_done_o || owner_o) err++;
        end
        checks++;
        if (err != 0) begin
            fails++;
            $display("FAIL reset_state: got %0d bad cycles (tx=%b ga=%b gb=%b busy=%b done=%b own=%b), want 0",
                     err, tx_o, grant_a_o, grant_b_o, tx_busy_o, tx_done_o, owner_o);
        end
        reset_i = 1'b0;
        model_last = 1'b1;
        check_grant("reset_first", 1, wb);
        req_a_i = 1'b0;
        // Without tick strobes the frame must not advance.
        err = 0;
        repeat (20) begin
            @(negedge clock);
            if (tx_o !== 1'b0 || tx_busy_o !== 1'b1 || tx_done_o) err++;
        end
        checks++;
        if (err != 0) begin
            fails++;
            $display("FAIL no_tick_stall: got %0d bad cycles, want tx=0 busy=1 held", err);
        end
        tick_en = 1'b1;
        follow_frame("reset_frame", b, 1'b0, bc);
    endtask

    task automatic test_single();
        int bc, g = 0;
        logic wb;
        while (!tick && g < 16) begin
            @(posedge clock);
            g++;
        end
        repeat (4) @(negedge clock);
        data_a_i = 8'h55;
        req_a_i  = 1'b1;
        check_grant("single", 2, wb);
        req_a_i = 1'b0;
        follow_frame("single_55", 8'h55, 1'b0, bc);
        checks++;
        if (bc != FRAME_TICKS * 4) begin
            fails++;
            $display("FAIL single_busy_len: got %0d clocks, want %0d", bc, FRAME_TICKS * 4);
        end
    endtask

    task automatic test_tie();
        int bc;
        logic wb;
        do_reset();
        data_a_i = 8'hA5; data_b_i = 8'h3C;
        req_a_i = 1'b1; req_b_i = 1'b1;
        check_grant("tie_first", 2, wb);
        req_a_i = 1'b0;
        follow_frame("tie_a", 8'hA5, 1'b0, bc);
        check_grant("tie_second", 1, wb);
        req_b_i = 1'b0;
        follow_frame("tie_b", 8'h3C, 1'b1, bc);
    endtask

    task automatic test_back_to_back();
        int bc;
        logic wb;
        logic [DB-1:0] b;
        string nm;
        data_a_i = DB'($urandom); data_b_i = DB'($urandom);
        req_a_i = 1'b1; req_b_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            nm = $sformatf("rr%0d", k);
            check_grant(nm, (k == 0) ? 2 : 1, wb);
            b = wb ? data_b_i : data_a_i;
            checks++;
            if (wb !== logic'(k % 2)) begin
                fails++;
                $display("FAIL %s order: got owner %b, want %b", nm, wb, logic'(k % 2));
            end
            follow_frame(nm, b, wb, bc);
            data_a_i = DB'($urandom);
            data_b_i = DB'($urandom);
        end
        req_a_i = 1'b0; req_b_i = 1'b0;
    endtask

    task automatic test_data_hold();
        int bc;
        logic wb;
        @(negedge clock);
        data_a_i = 8'h0F;
        req_a_i  = 1'b1;
        check_grant("hold", 2, wb);
        req_a_i  = 1'b0;
        data_a_i = 8'hF0;
        follow_frame("hold_0f", 8'h0F, 1'b0, bc);
    endtask

    task automatic test_reset_mid();
        int n = 0, steps = 0, err = 0, bc;
        logic wb;
        @(negedge clock);
        data_a_i = 8'hC3; data_b_i = 8'h81;
        req_a_i = 1'b1;
        check_grant("mid_pre", 2, wb);
        req_a_i = 1'b0;
        while (n < OS + 3 * OS + 5 && steps < 2000) begin
            @(posedge clock);
            if (tick) n++;
            @(negedge clock);
            steps++;
        end
        reset_i = 1'b1;
        #1;
        checks++;
        if (tx_o !== 1'b1 || tx_busy_o !== 1'b0 || tx_done_o !== 1'b0) begin
            fails++;
            $display("FAIL mid_reset_async: got tx=%b busy=%b done=%b, want 1 0 0", tx_o, tx_busy_o, tx_done_o);
        end
        repeat (8) begin
            @(negedge clock);
            if (tx_done_o || tx_busy_o || tx_o !== 1'b1) err++;
        end
        reset_i = 1'b0;
        model_last = 1'b1;
        repeat (40) begin
            @(negedge clock);
            if (tx_done_o || tx_busy_o) err++;
        end
        checks++;
        if (err != 0) begin
            fails++;
            $display("FAIL mid_reset_no_done: got %0d bad cycles, want idle and no done", err);
        end
        req_a_i = 1'b1; req_b_i = 1'b1;
        check_grant("mid_after", 1, wb);
        req_a_i = 1'b0; req_b_i = 1'b0;
        follow_frame("mid_after", 8'hC3, 1'b0, bc);
    endtask

    initial begin
        test_reset();
        test_single();
        test_tie();
        test_back_to_back();
        test_data_hold();
        test_reset_mid();
        repeat (4) @(negedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
Shares one serial transmitter between two requesters: debug/report unit on port A, loader echo on port B. Arbitrates round-robin, latches the winning byte and serialises it as an 8N1 frame. Paced by the 16x oversampling tick from the baud-rate generator. Sits between the debug unit and the tx pin.

Parameters:
DATA_BITS, 8, payload bits per frame, sent LSB first
OVERSAMPLE, 16, ticks per serial bit; must match the generator's DIVISION
STOP_TICKS, 16, ticks the stop bit is held high

Ports:
clock  input  1  system clock
reset_i  input  1  asynchronous, active-high reset
tick  input  1  1-cycle strobe from the baud-rate generator, OVERSAMPLE per bit
req_a_i  input  1  requester A wants to send; level, sampled in IDLE only
data_a_i  input  DATA_BITS  byte for A, captured on grant_a_o
req_b_i  input  1  requester B wants to send
data_b_i  input  DATA_BITS  byte for B, captured on grant_b_o
grant_a_o  output  1  1-cycle pulse: A's byte accepted
grant_b_o  output  1  1-cycle pulse: B's byte accepted
owner_o  output  1  0 = A, 1 = B; owner of the frame in flight
tx_busy_o  output  1  high from grant until the end of the stop bit
tx_done_o  output  1  1-cycle pulse on the last stop tick
tx_o  output  1  serial line, idle high

Behaviour:
- Reset (async, any state):
  - state = IDLE; tx_o = 1; grant_a_o = grant_b_o = 0; tx_busy_o = 0; tx_done_o = 0; owner_o = 0.
  - Tick counter, bit counter and shift register cleared.
  - last_grant = B, so A wins the first tie.
- FSM states: IDLE, START, DATA, STOP.
- IDLE, arbitration runs on every clock edge; tick is not required:
  - Only A requests -> grant A. Only B requests -> grant B.
  - Both request -> grant the one that is not last_grant.
  - On a grant: pulse that grant for 1 cycle, load the shift register from its data bus, set owner_o, update last_grant, set tx_busy_o, clear the tick counter, go to START.
  - Data is sampled on the grant edge only; later data changes are ignored.
- Tick counter counts tick strobes, not clocks. Clock edges without tick do nothing outside IDLE.
- START: tx_o = 0. After OVERSAMPLE ticks (counter reaches OVERSAMPLE-1 on a tick), clear the counter and bit index, go to DATA.
- DATA:
  - tx_o = shift register bit 0.
  - At each bit end (OVERSAMPLE ticks): shift right and increment the bit index.
  - After bit DATA_BITS-1, go to STOP.
- STOP: tx_o = 1. On tick STOP_TICKS-1, pulse tx_done_o, drop tx_busy_o, go to IDLE.
- Frame length is exactly (1+DATA_BITS)*OVERSAMPLE + STOP_TICKS ticks = 160 ticks at defaults.
- Requests are levels, not queued:
  - A requester still high in IDLE is granted again. Requesters drop req on seeing their grant.
  - Requests are ignored outside IDLE. No grant is issued while busy.
- Back-to-back: the earliest next grant is the clock after tx_done_o, since the FSM spends at least 1 cycle in IDLE. tx_o stays 1 across that gap.
- Reset mid-frame: tx_o returns to 1 immediately. The frame is aborted and no done pulse is issued.
- grant_a_o and grant_b_o are never high in the same cycle. Grants occur only when tx_busy_o was 0 in the previous cycle.
- Counter widths: clog2(OVERSAMPLE) for the tick counter (4 bits at defaults). Wrap is explicit at OVERSAMPLE-1, never natural overflow.

Test Plan:
- Reset with req_a_i=1 held -> tx_o=1, no grant while reset_i=1. First edge after release -> grant_a_o pulse, owner_o=0.
- A sends 0x55, tick every 4 clocks -> tx_o = 0 for 16 ticks, then 1,0,1,0,1,0,1,0 at 16 ticks each, then 1 for 16 ticks. tx_done_o after 160 ticks; tx_busy_o high for exactly 640 clocks.
- A and B request together with 0xA5 / 0x3C -> A granted first. B granted 1 clock after tx_done_o; second frame carries 0x3C LSB first with owner_o=1.
- Both requests held high for 4 frames -> grant order A,B,A,B. No two grants within one frame.
- data_a_i changed from 0x0F to 0xF0 one clock after grant -> line still carries 0x0F.
- reset_i asserted mid-DATA (bit 3) -> tx_o=1 and tx_busy_o=0 asynchronously. No tx_done_o pulse. Next request after release is granted to A.
